// File: rtl/key_rs_gen_pkg.sv
// Shared constants for the key-to-RS-pulse front end: key polarity helpers
// and default debounce timing for the 12 MHz board clock.
package key_rs_gen_pkg;

    localparam int unsigned DEF_CNT_MAX     = 240000;   // 20 ms at 12 MHz
    localparam int unsigned DEF_CNT_W       = 18;
    localparam bit          DEF_KEY_ACT_LOW = 1'b1;

    // Raw key level when pressed / released for a given polarity.
    function automatic logic key_pressed_lvl(input bit act_low);
        return ~act_low;
    endfunction

    function automatic logic key_released_lvl(input bit act_low);
        return act_low;
    endfunction

    localparam logic KEY_PRESSED  = key_pressed_lvl(DEF_KEY_ACT_LOW);
    localparam logic KEY_RELEASED = key_released_lvl(DEF_KEY_ACT_LOW);

endpackage

// File: rtl/key_rs_gen_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, debounced level
// and a registered one-cycle press pulse.
module key_debounce
    import key_rs_gen_pkg::*;
#(
    parameter int unsigned CNT_MAX     = DEF_CNT_MAX,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          KEY_ACT_LOW = DEF_KEY_ACT_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic lvl,
    output logic press
);

    localparam logic             REL      = key_released_lvl(KEY_ACT_LOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    if (CNT_MAX < 2) begin : g_bad_cnt_max
        $error("key_debounce: CNT_MAX must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(CNT_MAX)) begin : g_bad_cnt_w
        $error("key_debounce: CNT_W too small for CNT_MAX");
    end

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= REL;
            sync2    <= REL;
            stable   <= REL;
            stable_d <= REL;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= (stable != REL) && (stable_d == REL);
            // Counter only ever reaches CNT_LAST, so equality is the full test.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Delayed copy keeps the level aligned with the press pulse.
    assign lvl = (stable_d != REL);

endmodule

// File: rtl/key_rs_gen.sv
// SET/RESET push-buttons to clean, mutually exclusive one-cycle s/r pulses
// for the board's clocked RS flip-flop.
module key_rs_gen
    import key_rs_gen_pkg::*;
#(
    parameter int unsigned CNT_MAX     = DEF_CNT_MAX,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          KEY_ACT_LOW = DEF_KEY_ACT_LOW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_set,
    input  logic       key_rst,
    output logic       s,
    output logic       r,
    output logic [1:0] key_lvl
);

    logic press_set;
    logic press_rst;
    logic lvl_set;
    logic lvl_rst;

    key_debounce #(
        .CNT_MAX     (CNT_MAX),
        .CNT_W       (CNT_W),
        .KEY_ACT_LOW (KEY_ACT_LOW)
    ) u_set (
        .clk   (clk),
        .rst   (rst),
        .key   (key_set),
        .lvl   (lvl_set),
        .press (press_set)
    );

    key_debounce #(
        .CNT_MAX     (CNT_MAX),
        .CNT_W       (CNT_W),
        .KEY_ACT_LOW (KEY_ACT_LOW)
    ) u_rst (
        .clk   (clk),
        .rst   (rst),
        .key   (key_rst),
        .lvl   (lvl_rst),
        .press (press_rst)
    );

    // A press is honoured only when the other key is neither pressing nor held.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 1'b0;
            r <= 1'b0;
        end else begin
            s <= press_set & ~press_rst & ~lvl_rst;
            r <= press_rst & ~press_set & ~lvl_set;
        end
    end

    assign key_lvl = {lvl_rst, lvl_set};

endmodule
